obstacle_scheduler: RTL and testbench

Owns the on-screen obstacle slots fed by the spawner. Each rising edge of `spawn` captures a y value into the lowest free slot. Each movement tick shifts every active obstacle left by a fixed step and frees any obstacle that leaves the screen. The drawing FSM reads the active obstacles back one at a time over a valid/ack handshake.

---
 rtl/obstacle_pkg.sv | 9 +
 rtl/obstacle_scheduler_slot_select.sv | 33 +++
 rtl/obstacle_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_obstacle_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_pkg.sv
// Shared types and default geometry for the obstacle scheduler.
package obstacle_pkg;
   typedef enum logic [2:0] {IDLE, MOVE, SCAN, WAIT, DONE} state_e;

   localparam logic [9:0] X_START_DEF = 10'd639;
   localparam logic [9:0] STEP_DEF    = 10'd4;
   localparam logic [9:0] Y_MAX_DEF   = 10'd440;
   localparam logic [9:0] SCREEN_W    = 10'd640;
endpackage

// File: rtl/obstacle_scheduler_slot_select.sv
// Priority encoder over slot occupancy: lowest free slot for allocation,
// lowest active slot at or above ptr for the read-out scan.
module slot_select
   import obstacle_pkg::*;
#(
   parameter  int NUM_SLOTS = 4,
   localparam int PW        = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] active,
   input  logic [PW-1:0]        ptr,
   output logic [PW-1:0]        free_idx,
   output logic                 free_found,
   output logic [PW-1:0]        act_idx,
   output logic                 act_found
);
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      act_idx    = '0;
      act_found  = 1'b0;
      // Walk downward so the last hit is the lowest index.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!active[i]) begin
            free_idx   = i[PW-1:0];
            free_found = 1'b1;
         end
         if (active[i] && (i >= int'(ptr))) begin
            act_idx   = i[PW-1:0];
            act_found = 1'b1;
         end
      end
   end
endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle slot owner: spawn allocation, per-tick movement and a
// valid/ack read-out pass for the drawing FSM.
module obstacle_scheduler
   import obstacle_pkg::*;
#(
   parameter  int         NUM_SLOTS = 4,
   parameter  logic [9:0] X_START   = X_START_DEF,
   parameter  logic [9:0] STEP      = STEP_DEF,
   parameter  logic [9:0] Y_MAX     = Y_MAX_DEF,
   localparam int         PW        = $clog2(NUM_SLOTS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 spawn,
   input  logic [9:0]           spawn_y,
   input  logic                 tick,
   input  logic                 draw_req,
   input  logic                 obj_ack,
   output logic                 obj_valid,
   output logic [9:0]           obj_x,
   output logic [9:0]           obj_y,
   output logic [PW-1:0]        obj_slot,
   output logic                 draw_done,
   output logic [NUM_SLOTS-1:0] active,
   output logic [7:0]           drop_cnt,
   output logic                 busy
);
   localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);

   state_e                      state_q, state_d;
   logic                        spawn_q;
   logic                        spawn_pend_q, spawn_pend_d;
   logic                        tick_pend_q, tick_pend_d;
   logic                        draw_pend_q, draw_pend_d;
   logic [9:0]                  y_pend_q, y_pend_d;
   logic [7:0]                  drop_q, drop_d;
   logic [PW-1:0]               ptr_q, ptr_d;
   logic [NUM_SLOTS-1:0]        act_q, act_d;
   logic [NUM_SLOTS-1:0][9:0]   x_q, x_d, y_q, y_d;
   logic                        obj_valid_q, obj_valid_d;
   logic [9:0]                  obj_x_q, obj_x_d, obj_y_q, obj_y_d;
   logic [PW-1:0]               obj_slot_q, obj_slot_d;
   logic                        done_q, done_d;

   logic                        spawn_evt, serve_spawn, serve_tick, serve_draw, drop_inc;
   logic [PW-1:0]               free_idx, act_idx;
   logic                        free_found, act_found;

   slot_select #(.NUM_SLOTS(NUM_SLOTS)) u_sel (
      .active     (act_q),
      .ptr        (ptr_q),
      .free_idx   (free_idx),
      .free_found (free_found),
      .act_idx    (act_idx),
      .act_found  (act_found)
   );

   always_comb begin
      spawn_evt   = spawn & ~spawn_q;
      state_d     = state_q;
      ptr_d       = ptr_q;
      act_d       = act_q;
      x_d         = x_q;
      y_d         = y_q;
      obj_valid_d = obj_valid_q;
      obj_x_d     = obj_x_q;
      obj_y_d     = obj_y_q;
      obj_slot_d  = obj_slot_q;
      done_d      = 1'b0;
      serve_spawn = 1'b0;
      serve_tick  = 1'b0;
      serve_draw  = 1'b0;
      drop_inc    = 1'b0;
      y_pend_d    = y_pend_q;
      drop_d      = drop_q;

      if (enable) begin
         unique case (state_q)
            IDLE: begin
               if (spawn_pend_q) begin
                  serve_spawn = 1'b1;
                  if (free_found) begin
                     x_d[free_idx]   = X_START;
                     y_d[free_idx]   = y_pend_q;
                     act_d[free_idx] = 1'b1;
                  end else begin
                     drop_inc = 1'b1;
                  end
               end else if (tick_pend_q) begin
                  serve_tick = 1'b1;
                  ptr_d      = '0;
                  state_d    = MOVE;
               end else if (draw_pend_q) begin
                  serve_draw = 1'b1;
                  ptr_d      = '0;
                  state_d    = SCAN;
               end
            end
            MOVE: begin
               if (act_q[ptr_q]) begin
                  if (x_q[ptr_q] < STEP) act_d[ptr_q] = 1'b0;
                  else                   x_d[ptr_q]   = x_q[ptr_q] - STEP;
               end
               if (ptr_q == LAST) state_d = IDLE;
               else               ptr_d   = ptr_q + 1'b1;
            end
            SCAN: begin
               if (act_found) begin
                  obj_valid_d = 1'b1;
                  obj_x_d     = x_q[act_idx];
                  obj_y_d     = y_q[act_idx];
                  obj_slot_d  = act_idx;
                  state_d     = WAIT;
               end else begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
            WAIT: begin
               if (obj_ack) begin
                  obj_valid_d = 1'b0;
                  if (obj_slot_q == LAST) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else begin
                     ptr_d   = obj_slot_q + 1'b1;
                     state_d = SCAN;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      // A new edge while an older spawn is still queued replaces it.
      if (spawn_evt) begin
         y_pend_d = (spawn_y > Y_MAX) ? Y_MAX : spawn_y;
         if (spawn_pend_q && !serve_spawn) drop_inc = 1'b1;
      end
      spawn_pend_d = (spawn_pend_q & ~serve_spawn) | spawn_evt;
      tick_pend_d  = (tick_pend_q & ~serve_tick) | tick;
      draw_pend_d  = (draw_pend_q & ~serve_draw) | draw_req;
      if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         spawn_q      <= 1'b0;
         spawn_pend_q <= 1'b0;
         tick_pend_q  <= 1'b0;
         draw_pend_q  <= 1'b0;
         y_pend_q     <= '0;
         drop_q       <= '0;
         ptr_q        <= '0;
         act_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         obj_valid_q  <= 1'b0;
         obj_x_q      <= '0;
         obj_y_q      <= '0;
         obj_slot_q   <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         spawn_q      <= spawn;
         spawn_pend_q <= spawn_pend_d;
         tick_pend_q  <= tick_pend_d;
         draw_pend_q  <= draw_pend_d;
         y_pend_q     <= y_pend_d;
         drop_q       <= drop_d;
         ptr_q        <= ptr_d;
         act_q        <= act_d;
         x_q          <= x_d;
         y_q          <= y_d;
         obj_valid_q  <= obj_valid_d;
         obj_x_q      <= obj_x_d;
         obj_y_q      <= obj_y_d;
         obj_slot_q   <= obj_slot_d;
         done_q       <= done_d;
      end
   end

   assign obj_valid = obj_valid_q;
   assign obj_x     = obj_x_q;
   assign obj_y     = obj_y_q;
   assign obj_slot  = obj_slot_q;
   assign draw_done = done_q;
   assign active    = act_q;
   assign drop_cnt  = drop_q;
   assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: directed scenarios plus a randomized run
// against a slot-list model of spawn / move / read-out behaviour.
module tb_obstacle_scheduler;
   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          reset, enable, spawn, tick, draw_req, obj_ack;
   logic [9:0]    spawn_y, obj_x, obj_y;
   logic          obj_valid, draw_done, busy;
   logic [1:0]    obj_slot;
   logic [NS-1:0] active;
   logic [7:0]    drop_cnt;

   int passed = 0, total = 0;

   // reference model: plain slot list
   bit m_act[NS];
   int m_x[NS], m_y[NS];
   int m_drop;

   // observations of the last read-out pass
   int obs_slot[$], obs_x[$], obs_y[$];
   bit pass_stable, pass_to;
   int done_cnt, first_lat, last_busy;

   obstacle_scheduler dut (
      .clk(clk), .reset(reset), .enable(enable), .spawn(spawn), .spawn_y(spawn_y),
      .tick(tick), .draw_req(draw_req), .obj_ack(obj_ack), .obj_valid(obj_valid),
      .obj_x(obj_x), .obj_y(obj_y), .obj_slot(obj_slot), .draw_done(draw_done),
      .active(active), .drop_cnt(drop_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void m_clear();
      for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_drop = 0;
   endfunction

   function automatic void m_spawn(input int y);
      int yc = (y > 440) ? 440 : y;
      for (int i = 0; i < NS; i++)
         if (!m_act[i]) begin m_act[i] = 1; m_x[i] = 639; m_y[i] = yc; return; end
      if (m_drop < 255) m_drop++;
   endfunction

   function automatic void m_tick();
      for (int i = 0; i < NS; i++)
         if (m_act[i]) begin
            if (m_x[i] < 4) m_act[i] = 0;
            else m_x[i] -= 4;
         end
   endfunction

   function automatic logic [NS-1:0] m_vec();
      logic [NS-1:0] v = '0;
      for (int i = 0; i < NS; i++) v[i] = m_act[i];
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b0; enable = 1'b1; spawn = 1'b0; spawn_y = '0;
      tick = 1'b0; draw_req = 1'b0; obj_ack = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      m_clear();
      @(negedge clk);
   endtask

   task automatic spawn_op(input int y);
      @(negedge clk); spawn = 1'b1; spawn_y = 10'(y);
      @(negedge clk); spawn = 1'b0;
      @(negedge clk);
      m_spawn(y);
   endtask

   task automatic tick_op();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      last_busy = 0;
      repeat (NS + 4) begin @(negedge clk); if (busy) last_busy++; end
      m_tick();
   endtask

   task automatic collect_pass(input int dly);
      obs_slot.delete(); obs_x.delete(); obs_y.delete();
      pass_stable = 1; pass_to = 1; done_cnt = 0; first_lat = -1;
      for (int c = 0; c < 400 && pass_to; c++) begin
         @(negedge clk);
         if ((draw_done || obj_valid) && first_lat < 0) first_lat = c + 2;
         if (draw_done) begin
            done_cnt++; pass_to = 0;
         end else if (obj_valid) begin
            obs_slot.push_back(int'(obj_slot));
            obs_x.push_back(int'(obj_x));
            obs_y.push_back(int'(obj_y));
            for (int d = 0; d < dly; d++) begin
               @(negedge clk);
               if (!obj_valid || int'(obj_slot) != obs_slot[$] || int'(obj_x) != obs_x[$]
                   || int'(obj_y) != obs_y[$]) pass_stable = 0;
            end
            obj_ack = 1'b1;
            @(negedge clk);
            obj_ack = 1'b0;
            if (draw_done) begin done_cnt++; pass_to = 0; end
         end
      end
      repeat (3) begin @(negedge clk); if (draw_done) done_cnt++; end
   endtask

   task automatic run_pass(input int dly);
      @(negedge clk); draw_req = 1'b1;
      @(negedge clk); draw_req = 1'b0;
      collect_pass(dly);
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (active !== 4'b0000) $display("FAIL reset_active got %b want 0000", active); else passed++;
      total++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else passed++;
      total++;
      if ({obj_valid, obj_x, obj_y, obj_slot, draw_done, busy} !== '0)
         $display("FAIL reset_outputs got v=%b x=%0d y=%0d s=%0d d=%b b=%b want all 0",
                  obj_valid, obj_x, obj_y, obj_slot, draw_done, busy);
      else passed++;
      run_pass(0);
      total++; if (first_lat != 3) $display("FAIL empty_pass_latency got %0d want 3", first_lat); else passed++;
      total++; if (done_cnt != 1 || obs_slot.size() != 0)
         $display("FAIL empty_pass got done=%0d objs=%0d want 1/0", done_cnt, obs_slot.size()); else passed++;
   endtask

   task automatic test_spawn_held();
      do_reset();
      @(negedge clk); spawn = 1'b1; spawn_y = 10'd100;
      repeat (30) @(negedge clk);
      spawn = 1'b0;
      @(negedge clk);
      total++; if (active !== 4'b0001) $display("FAIL held_active got %b want 0001", active); else passed++;
      total++; if (drop_cnt !== 8'd0) $display("FAIL held_drop got %0d want 0", drop_cnt); else passed++;
      run_pass(1);
      total++; if (obs_slot.size() != 1 || obs_slot[0] != 0 || obs_x[0] != 639 || obs_y[0] != 100)
         $display("FAIL held_slot got n=%0d x=%0d y=%0d want 1 x=639 y=100", obs_slot.size(), obs_x[0], obs_y[0]);
      else passed++;
      total++; if (first_lat != 3) $display("FAIL valid_latency got %0d want 3", first_lat); else passed++;
   endtask

   task automatic test_clamp();
      do_reset();
      spawn_op(900);
      run_pass(0);
      total++; if (obs_y.size() != 1 || obs_y[0] != 440)
         $display("FAIL clamp_y got %0d want 440", obs_y[0]); else passed++;
   endtask

   task automatic test_fill_drop();
      do_reset();
      for (int i = 0; i < 5; i++) spawn_op(int'($urandom_range(0, 440)));
      total++; if (active !== 4'b1111) $display("FAIL fill_active got %b want 1111", active); else passed++;
      total++; if (drop_cnt !== 8'd1) $display("FAIL fill_drop got %0d want 1", drop_cnt); else passed++;
   endtask

   task automatic test_move_free();
      do_reset();
      spawn_op(50);
      repeat (159) tick_op();
      total++; if (last_busy != NS) $display("FAIL move_busy got %0d want %0d", last_busy, NS); else passed++;
      run_pass(0);
      total++; if (obs_x.size() != 1 || obs_x[0] != 3)
         $display("FAIL move_last_x got %0d want 3", obs_x[0]); else passed++;
      tick_op();
      total++; if (active !== 4'b0000) $display("FAIL move_freed got %b want 0000", active); else passed++;
      total++; if (last_busy != NS) $display("FAIL free_busy got %0d want %0d", last_busy, NS); else passed++;
   endtask

   task automatic test_draw_ack();
      do_reset();
      spawn_op(11); repeat (40) tick_op();
      spawn_op(22); repeat (120) tick_op();
      spawn_op(33); spawn_op(44); repeat (40) tick_op();
      spawn_op(55); spawn_op(66); repeat (120) tick_op();
      total++; if (active !== 4'b1010) $display("FAIL ack_setup got %b want 1010", active); else passed++;
      run_pass(3);
      total++; if (obs_slot.size() != 2 || obs_slot[0] != 1 || obs_slot[1] != 3)
         $display("FAIL ack_order got n=%0d first=%0d want slots 1,3", obs_slot.size(), obs_slot[0]); else passed++;
      total++; if (obs_x.size() != 2 || obs_x[0] != 159 || obs_x[1] != 159 || obs_y[0] != 55 || obs_y[1] != 66)
         $display("FAIL ack_values got x0=%0d y0=%0d want 159/55", obs_x[0], obs_y[0]); else passed++;
      total++; if (!pass_stable) $display("FAIL ack_stable got unstable want stable"); else passed++;
      total++; if (done_cnt != 1) $display("FAIL ack_done got %0d want 1", done_cnt); else passed++;
   endtask

   task automatic test_same_edge();
      do_reset();
      @(negedge clk); spawn = 1'b1; spawn_y = 10'd200; tick = 1'b1; draw_req = 1'b1;
      @(negedge clk); tick = 1'b0; draw_req = 1'b0;
      @(negedge clk); spawn = 1'b0;
      collect_pass(0);
      total++; if (obs_x.size() != 1 || obs_x[0] != 635 || obs_y[0] != 200)
         $display("FAIL same_edge got n=%0d x=%0d y=%0d want 1 x=635 y=200", obs_x.size(), obs_x[0], obs_y[0]);
      else passed++;
      total++; if (done_cnt != 1) $display("FAIL same_edge_done got %0d want 1", done_cnt); else passed++;
   endtask

   task automatic test_pending_overwrite();
      do_reset();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0; spawn = 1'b1; spawn_y = 10'd10;
      @(negedge clk); spawn = 1'b0;
      @(negedge clk); spawn = 1'b1; spawn_y = 10'd20;
      @(negedge clk); spawn = 1'b0;
      repeat (8) @(negedge clk);
      total++; if (drop_cnt !== 8'd1) $display("FAIL overwrite_drop got %0d want 1", drop_cnt); else passed++;
      run_pass(0);
      total++; if (obs_y.size() != 1 || obs_y[0] != 20 || obs_x[0] != 639)
         $display("FAIL overwrite_slot got n=%0d x=%0d y=%0d want 1 x=639 y=20", obs_y.size(), obs_x[0], obs_y[0]);
      else passed++;
   endtask

   task automatic test_freeze();
      bit got = 0;
      do_reset();
      spawn_op(77);
      enable = 1'b0;
      tick_op();
      total++; if (last_busy != 0) $display("FAIL freeze_idle got busy=%0d want 0", last_busy); else passed++;
      enable = 1'b1;
      repeat (8) @(negedge clk);
      @(negedge clk); draw_req = 1'b1;
      @(negedge clk); draw_req = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = obj_valid; end
      total++; if (!got) $display("FAIL freeze_valid got timeout want obj_valid"); else passed++;
      enable = 1'b0; obj_ack = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (obj_valid !== 1'b1 || obj_x !== 10'd635)
         $display("FAIL freeze_hold got v=%b x=%0d want 1 x=635", obj_valid, obj_x); else passed++;
      obj_ack = 1'b0; enable = 1'b1;
      collect_pass(0);
      total++; if (obs_x.size() != 1 || obs_x[0] != 635 || done_cnt != 1)
         $display("FAIL freeze_resume got n=%0d done=%0d want 1/1", obs_x.size(), done_cnt); else passed++;
   endtask

   task automatic test_reset_mid_pass();
      bit got = 0;
      int late_done = 0;
      do_reset();
      spawn_op(123);
      @(negedge clk); draw_req = 1'b1;
      @(negedge clk); draw_req = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin @(negedge clk); got = obj_valid; end
      #2 reset = 1'b0;
      #1;
      total++; if (obj_valid !== 1'b0 || busy !== 1'b0 || active !== 4'b0000 || obj_x !== 10'd0)
         $display("FAIL midreset got v=%b b=%b act=%b x=%0d want all 0", obj_valid, busy, active, obj_x);
      else passed++;
      @(negedge clk); reset = 1'b1;
      m_clear();
      repeat (10) begin @(negedge clk); if (draw_done) late_done++; end
      total++; if (late_done != 0) $display("FAIL midreset_done got %0d want 0", late_done); else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int it = 0; it < 50; it++) begin
         int op = int'($urandom_range(0, 3));
         if (op <= 1) spawn_op(int'($urandom_range(0, 1023)));
         else if (op == 2) repeat ($urandom_range(1, 50)) tick_op();
         else begin
            int k = 0;
            run_pass(int'($urandom_range(0, 3)));
            total++; if (done_cnt != 1 || !pass_stable)
               $display("FAIL rnd_pass it=%0d got done=%0d stable=%0d want 1/1", it, done_cnt, pass_stable);
            else passed++;
            for (int i = 0; i < NS; i++) if (m_act[i]) begin
               total++;
               if (k >= obs_slot.size() || obs_slot[k] != i || obs_x[k] != m_x[i] || obs_y[k] != m_y[i])
                  $display("FAIL rnd_obj it=%0d slot %0d got x=%0d y=%0d want x=%0d y=%0d",
                           it, i, (k < obs_x.size()) ? obs_x[k] : -1, (k < obs_y.size()) ? obs_y[k] : -1, m_x[i], m_y[i]);
               else passed++;
               k++;
            end
            total++; if (obs_slot.size() != k) $display("FAIL rnd_count got %0d want %0d", obs_slot.size(), k); else passed++;
         end
         total++; if (active !== m_vec()) $display("FAIL rnd_active it=%0d got %b want %b", it, active, m_vec()); else passed++;
         total++; if (int'(drop_cnt) != m_drop) $display("FAIL rnd_drop it=%0d got %0d want %0d", it, drop_cnt, m_drop); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_spawn_held();
      test_clamp();
      test_fill_drop();
      test_move_free();
      test_draw_ack();
      test_same_edge();
      test_pending_overwrite();
      test_freeze();
      test_reset_mid_pass();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
